sd_block_responder: RTL
=======================

# sd_block_responder

Serves 512-byte block requests from a track buffer. It sits on the responder side of the `sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`/`sd_buff_*` handshake and moves block data to and from a byte-wide disk-image store (BRAM or SDRAM port). It lets floppy and other block devices run without the HPS I/O controller, in simulation or in stand-alone builds.

## Interface
- `IMG_AW`, default 18: byte address width of the image store. The default is 256 KiB, which holds a 140 KiB .dsk image.
- `ACK_DELAY`, default 4: idle cycles between sampling a request and raising `sd_ack`. Range 0–255.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `sd_lba`  in  32  block number; sampled with the request
- `sd_rd`  in  1  read request (level)
- `sd_wr`  in  1  write request (level)
- `sd_ack`  out  1  high for the whole transfer
- `sd_buff_addr`  out  9  byte index within the block
- `sd_buff_dout`  out  8  read data to the requester
- `sd_buff_din`  in  8  write data from the requester (registered BRAM output)
- `sd_buff_wr`  out  1  one-cycle strobe: `sd_buff_dout` is valid at `sd_buff_addr`
- `img_blocks`  in  16  image size in 512-byte blocks
- `img_addr`  out  IMG_AW  store byte address = {lba[IMG_AW-10:0], beat}
- `img_rd`, `img_wr`  out  1  store request; held until `img_ready`
- `img_din`  out  8  store write data
- `img_dout`  in  8  store read data; valid when `img_ready` is high
- `img_ready`  in  1  store completes the current access
- `busy`  out  1  high from request accept until return to IDLE
- `err`  out  1  sticky protocol/range error
- `rd_count`, `wr_count`  out  16  completed blocks (see Configuration)

## Operation
- States: IDLE → DELAY → RBEAT/WBEAT → DONE → IDLE.
- IDLE:
  - When `sd_rd|sd_wr` is high, latch `sd_lba` and the direction, set `busy`, and load the delay counter with ACK_DELAY.
  - If both requests are high, serve a read and set `err`.
- DELAY: count down to 0, then raise `sd_ack` and set beat to 0.
- Requester behaviour: it drops `sd_rd`/`sd_wr` on seeing `sd_ack`. While not in IDLE, requests are ignored.
- RBEAT (read): per beat:
  - Assert `img_rd` with `img_addr` until `img_ready`.
  - On the next cycle, drive `sd_buff_addr`=beat, `sd_buff_dout`=captured byte and `sd_buff_wr`=1 for exactly 1 cycle.
  - Increment beat.
- WBEAT (write): per beat:
  - Drive `sd_buff_addr`=beat and hold it 2 cycles.
  - Capture `sd_buff_din` on the second edge.
  - Assert `img_wr` with `img_din` until `img_ready`, then increment beat.
- Completion: after beat 511 finishes (9-bit beat counter, no wrap into beat 0), go to DONE. DONE deasserts `sd_ack` and `busy` and returns to IDLE.
- Out of range (`sd_lba >= {16'b0,img_blocks}`):
  - Set `err`; no `img_*` accesses are issued.
  - Read: deliver 512 strobes of 0x00 at 1 beat per 2 cycles.
  - Write: ack and consume addresses at the same rate, discarding the data.
- `img_blocks`=0: every request is out of range.

## Timing
- Reset values: `sd_ack`, `sd_buff_wr`, `img_rd`, `img_wr`, `busy` and `err` = 0. `sd_buff_addr`, `sd_buff_dout`, `img_addr` and `img_din` = 0. Counters = 0.
- Reset mid-transfer: everything returns to reset values the next cycle and any store access is dropped.
- `sd_ack` rises ACK_DELAY+1 cycles after the request is sampled.
- Read beat with `img_ready` returned the cycle after the request: 3 cycles. Whole block ≈ 1536 cycles.
- Write beat with the same store latency: 3 cycles.
- `sd_ack` falls 1 cycle after the final strobe or final `img_ready`.
- A new request asserted the cycle after `sd_ack` falls is sampled within 2 cycles. This supports back-to-back 13-block track loads.
- `sd_buff_addr` is stable while `sd_buff_wr` is high.

## Configuration
- `SD_RESP_STATS_EN` defined:
  - `rd_count`/`wr_count` increment on entering DONE for in-range reads/writes.
  - They wrap at 16 bits and are cleared by reset.
- Not defined: both ports are constant 0 and no counter logic is built.

## Test plan
- Read, `sd_lba`=3, `img_blocks`=280, ACK_DELAY=4, store pattern byte = addr[7:0]^addr[15:8]: 512 `sd_buff_wr` strobes with addr 0..511, data matching the pattern at store 0x600+i. `sd_ack` rises 5 cycles after the request.
- Write, `sd_lba`=0x10, requester BRAM filled with 0xA5^i: store bytes 0x2000..0x21FF match, `err`=0, `wr_count`=1 with the macro defined.
- 13 back-to-back reads, `sd_lba` 26..38, each issued on the `sd_ack` falling edge: 13 acks, 6656 strobes total, no request lost.
- `sd_lba`=280 with `img_blocks`=280: 512 strobes of 0x00, `err`=1, no `img_rd` pulses.
- Reset asserted at beat 100 of a read: the next cycle `sd_ack`=0, `busy`=0, `img_rd`=0. A following read of `sd_lba`=1 completes normally.
- `sd_rd`=`sd_wr`=1 together: a read is served and `err`=1.

Source files
------------

// File: rtl/sd_block_responder.sv
// sd_block_responder: serves 512-byte sd_* block requests from a byte-wide
// disk-image store, standing in for the HPS I/O controller.
// Ports: clk/reset (sync, active-high); sd_lba/sd_rd/sd_wr/sd_ack and
// sd_buff_addr/dout/din/wr requester side; img_* store side (held until
// img_ready); busy, sticky err, rd_count/wr_count.
// Optional: define SD_RESP_STATS_EN to build the completed-block counters.
module sd_block_responder #(
  parameter int unsigned IMG_AW    = 18,
  parameter int unsigned ACK_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              sd_buff_wr,
  input  logic [15:0]       img_blocks,
  output logic [IMG_AW-1:0] img_addr,
  output logic              img_rd,
  output logic              img_wr,
  output logic [7:0]        img_din,
  input  logic [7:0]        img_dout,
  input  logic              img_ready,
  output logic              busy,
  output logic              err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DELAY = 3'd1;
  localparam logic [2:0] S_RBEAT = 3'd2;
  localparam logic [2:0] S_WBEAT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q;
  logic [IMG_AW-10:0] lba_q;
  logic              is_wr_q;
  logic              oor_q;
  logic [7:0]        cnt_q;
  logic [8:0]        beat_q;
  logic [1:0]        ph_q;
  logic              ack_q;
  logic [8:0]        baddr_q;
  logic [7:0]        bdout_q;
  logic              bwr_q;
  logic [IMG_AW-1:0] iaddr_q;
  logic              ird_q;
  logic              iwr_q;
  logic [7:0]        idin_q;
  logic              busy_q;
  logic              err_q;

  logic       last;
  logic [8:0] beat_n;
  logic       req_oor;
  logic       fin;

  assign last    = (beat_q == 9'h1FF);
  assign beat_n  = beat_q + 9'd1;
  assign req_oor = (sd_lba >= {16'b0, img_blocks});

  // Final beat completes: read strobe cycle, out-of-range write
  // second address cycle, or in-range write store handshake.
  assign fin = last &
    (((state_q == S_RBEAT) & (ph_q == 2'd1)) |
     ((state_q == S_WBEAT) &
      (((ph_q == 2'd1) & oor_q) |
       ((ph_q == 2'd2) & img_ready))));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lba_q   <= '0;
      is_wr_q <= 1'b0;
      oor_q   <= 1'b0;
      cnt_q   <= 8'd0;
      beat_q  <= 9'd0;
      ph_q    <= 2'd0;
      ack_q   <= 1'b0;
      baddr_q <= 9'd0;
      bdout_q <= 8'd0;
      bwr_q   <= 1'b0;
      iaddr_q <= '0;
      ird_q   <= 1'b0;
      iwr_q   <= 1'b0;
      idin_q  <= 8'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      bwr_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (sd_rd | sd_wr) begin
            lba_q   <= sd_lba[IMG_AW-10:0];
            is_wr_q <= ~sd_rd;
            oor_q   <= req_oor;
            cnt_q   <= 8'(ACK_DELAY);
            busy_q  <= 1'b1;
            state_q <= S_DELAY;
            if ((sd_rd & sd_wr) | req_oor)
              err_q <= 1'b1;
          end
        end
        S_DELAY: begin
          if (cnt_q == 8'd0) begin
            ack_q   <= 1'b1;
            beat_q  <= 9'd0;
            ph_q    <= 2'd0;
            baddr_q <= 9'd0;
            iaddr_q <= {lba_q, 9'd0};
            ird_q   <= ~is_wr_q & ~oor_q;
            state_q <= is_wr_q ? S_WBEAT : S_RBEAT;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_RBEAT: begin
          // ph 0: fetch (or idle cycle when out of range), ph 1: strobe
          if (ph_q == 2'd0) begin
            if (oor_q | img_ready) begin
              ird_q   <= 1'b0;
              bwr_q   <= 1'b1;
              baddr_q <= beat_q;
              bdout_q <= oor_q ? 8'h00 : img_dout;
              ph_q    <= 2'd1;
            end
          end else begin
            ph_q <= 2'd0;
            if (!last) begin
              beat_q  <= beat_n;
              iaddr_q <= {lba_q, beat_n};
              ird_q   <= ~oor_q;
            end
          end
        end
        S_WBEAT: begin
          // ph 0: first address cycle, ph 1: capture din,
          // ph 2: store write; next address is shown meanwhile
          // so the requester BRAM output is ready on return to ph 1.
          unique case (ph_q)
            2'd0: ph_q <= 2'd1;
            2'd1: begin
              if (oor_q) begin
                if (!last) begin
                  beat_q  <= beat_n;
                  baddr_q <= beat_n;
                  ph_q    <= 2'd0;
                end
              end else begin
                idin_q  <= sd_buff_din;
                iwr_q   <= 1'b1;
                iaddr_q <= {lba_q, beat_q};
                baddr_q <= last ? beat_q : beat_n;
                ph_q    <= 2'd2;
              end
            end
            default: begin
              if (img_ready) begin
                iwr_q <= 1'b0;
                if (!last) begin
                  beat_q <= beat_n;
                  ph_q   <= 2'd1;
                end
              end
            end
          endcase
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (fin) begin
        ack_q   <= 1'b0;
        state_q <= S_DONE;
      end
    end
  end

`ifdef SD_RESP_STATS_EN
  logic [15:0] rdc_q;
  logic [15:0] wrc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdc_q <= 16'd0;
      wrc_q <= 16'd0;
    end else if (fin & ~oor_q) begin
      if (is_wr_q) wrc_q <= wrc_q + 16'd1;
      else         rdc_q <= rdc_q + 16'd1;
    end
  end

  assign rd_count = rdc_q;
  assign wr_count = wrc_q;
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

  assign sd_ack       = ack_q;
  assign sd_buff_addr = baddr_q;
  assign sd_buff_dout = bdout_q;
  assign sd_buff_wr   = bwr_q;
  assign img_addr     = iaddr_q;
  assign img_rd       = ird_q;
  assign img_wr       = iwr_q;
  assign img_din      = idin_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule
